// File: rtl/alu_result_fifo.sv
// alu_result_fifo: small first-word-fall-through queue that buffers ALU
// results (y plus five flags) under valid/ready handshakes on both sides,
// and keeps a sticky overflow bit and a saturating equality-event counter.
module alu_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_y,
  input  logic                     in_parity,
  input  logic                     in_overflow,
  input  logic                     in_greater,
  input  logic                     in_is_eq,
  input  logic                     in_less,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_y,
  output logic [4:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     sticky_ovf,
  input  logic                     clr_sticky,
  output logic [7:0]               eq_events
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = W + 5;
  localparam logic [AW:0]   FULL_CNT = DEPTH;
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   count_q, count_d;
  logic          sticky_q, sticky_d;
  logic [7:0]    eq_q, eq_d;
  logic          full, empty, push, pop;
  logic [EW-1:0] head;

  // Handshake qualifiers come from registered occupancy only, so in_ready
  // never depends combinationally on out_ready.
  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Fall-through head: the entry at rp is always on the outputs.
  assign head       = mem_q[rp_q];
  assign out_y      = head[W-1:0];
  assign out_flags  = head[EW-1:W];
  assign count      = count_q;
  assign sticky_ovf = sticky_q;
  assign eq_events  = eq_q;

  // Next-state for pointers, occupancy and status; set beats clear on sticky.
  always_comb begin
    wp_d     = wp_q;
    rp_d     = rp_q;
    count_d  = count_q;
    sticky_d = sticky_q;
    eq_d     = eq_q;
    if (push) wp_d = wp_q + PTR_ONE;
    if (pop)  rp_d = rp_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    if (push && in_overflow) sticky_d = 1'b1;
    else if (clr_sticky)     sticky_d = 1'b0;
    if (push && in_is_eq && (eq_q != 8'hFF)) eq_d = eq_q + 8'd1;
  end

  // Control state registers; reset discards all queued entries at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q     <= '0;
      rp_q     <= '0;
      count_q  <= '0;
      sticky_q <= 1'b0;
      eq_q     <= 8'd0;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
      eq_q     <= eq_d;
    end
  end

  // Storage array is not reset; entries are only meaningful while counted.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= {in_less, in_is_eq, in_greater, in_overflow, in_parity, in_y};
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: randomized and directed stimulus against a queue-based
// reference model; a negedge monitor pops expected results as the DUT pops.
module tb_alu_result_fifo;

  localparam int DEPTH = 4;
  localparam int W     = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_y;
  logic          in_parity, in_overflow, in_greater, in_is_eq, in_less;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_y;
  logic [4:0]    out_flags;
  logic [CW-1:0] count;
  logic          sticky_ovf, clr_sticky;
  logic [7:0]    eq_events;

  int nCompared = 0;
  int nFail     = 0;

  // Reference model: expected results in order, plus occupancy and status.
  logic [W+4:0] expQ [$];
  logic [W+4:0] headExp;
  int           mCount  = 0;
  bit           mSticky = 0;
  int           mEq     = 0;
  bit           mPush, mPop;

  alu_result_fifo #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y),
    .in_parity(in_parity), .in_overflow(in_overflow), .in_greater(in_greater),
    .in_is_eq(in_is_eq), .in_less(in_less),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_flags(out_flags), .count(count),
    .sticky_ovf(sticky_ovf), .clr_sticky(clr_sticky), .eq_events(eq_events)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs; returns 1 time unit after the next rising edge.
  // f is {less, is_eq, greater, overflow, parity}.
  task automatic applyStimulus(input bit v, input logic [7:0] y, input logic [4:0] f,
                               input bit rdy, input bit clr);
    in_valid   = v;
    in_y       = y;
    {in_less, in_is_eq, in_greater, in_overflow, in_parity} = f;
    out_ready  = rdy;
    clr_sticky = clr;
    @(posedge clk);
    #1;
  endtask

  // Model update at each rising edge from the handshake rules alone.
  always @(posedge clk) begin
    if (!rst) begin
      mPop  = (mCount > 0) && out_ready;
      mPush = in_valid && (mCount < DEPTH);
      if (mPush) expQ.push_back({in_less, in_is_eq, in_greater, in_overflow, in_parity, in_y});
      if (mPush && in_overflow) mSticky = 1;
      else if (clr_sticky)      mSticky = 0;
      if (mPush && in_is_eq && mEq < 255) mEq = mEq + 1;
      mCount = mCount + (mPush ? 1 : 0) - (mPop ? 1 : 0);
    end
  end

  // Monitor: status checks every cycle, data checks whenever the DUT pops.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("out_valid", out_valid, mCount > 0);
      checkOutput("in_ready", in_ready, mCount < DEPTH);
      checkOutput("count", count, mCount);
      checkOutput("sticky_ovf", sticky_ovf, mSticky);
      checkOutput("eq_events", eq_events, mEq);
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          nCompared++;
          nFail++;
          $display("[TB] FAIL pop_unexpected: got out_y %0h, expected no entry", out_y);
        end else begin
          headExp = expQ.pop_front();
          checkOutput("out_y", out_y, headExp[W-1:0]);
          checkOutput("out_flags", out_flags, headExp[W+4:W]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 0; in_y = '0; out_ready = 0; clr_sticky = 0;
    {in_less, in_is_eq, in_greater, in_overflow, in_parity} = 5'b0;
    #2;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_count", count, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill, refused fifth push, then ordered drain.
    applyStimulus(1, 8'h11, 5'b0, 0, 0);
    applyStimulus(1, 8'h22, 5'b0, 0, 0);
    applyStimulus(1, 8'h33, 5'b0, 0, 0);
    applyStimulus(1, 8'h44, 5'b0, 0, 0);
    checkOutput("fill_count", count, 4);
    checkOutput("fill_in_ready", in_ready, 0);
    applyStimulus(1, 8'h55, 5'b0, 0, 0);
    checkOutput("fifth_refused_count", count, 4);
    checkOutput("fill_head", out_y, 8'h11);
    repeat (4) applyStimulus(0, 8'h00, 5'b0, 1, 0);
    checkOutput("drain_count", count, 0);

    // Full boundary: pop only while full, then push+pop holds count.
    for (int i = 0; i < 4; i++) applyStimulus(1, 8'($urandom), 5'b0, 0, 0);
    applyStimulus(1, 8'h66, 5'b0, 1, 0);
    checkOutput("full_pop_only", count, 3);
    applyStimulus(1, 8'h66, 5'b0, 1, 0);
    checkOutput("push_pop_hold", count, 3);
    repeat (4) applyStimulus(0, 8'h00, 5'b0, 1, 0);

    // Flag packing and sticky overflow set/clear priority.
    applyStimulus(1, 8'h80, 5'b10011, 0, 0);
    checkOutput("flag_pack", out_flags, 5'b10011);
    checkOutput("flag_y", out_y, 8'h80);
    checkOutput("sticky_set", sticky_ovf, 1);
    applyStimulus(1, 8'h81, 5'b00010, 0, 1);
    checkOutput("sticky_set_wins", sticky_ovf, 1);
    applyStimulus(0, 8'h00, 5'b0, 0, 1);
    checkOutput("sticky_cleared", sticky_ovf, 0);
    repeat (3) applyStimulus(0, 8'h00, 5'b0, 1, 0);

    // Streaming through pointer wrap with the consumer always ready.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 8'(i * 7 + 3), 5'($urandom), 1, 0);
      checkOutput("stream_count_le1", count <= 1, 1);
    end
    applyStimulus(0, 8'h00, 5'b0, 1, 0);

    // Equality-event counter saturation.
    for (int i = 0; i < 260; i++) applyStimulus(1, 8'($urandom), 5'b01000, 1, 0);
    checkOutput("eq_saturated", eq_events, 255);
    for (int i = 0; i < 5; i++) applyStimulus(1, 8'($urandom), 5'($urandom) & 5'b10111, 1, 0);
    checkOutput("eq_held", eq_events, 255);
    applyStimulus(0, 8'h00, 5'b0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      applyStimulus(1'($urandom), 8'($urandom), 5'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
    repeat (6) applyStimulus(0, 8'h00, 5'b0, 1, 0);

    // Mid-cycle reset with three entries queued and status set.
    applyStimulus(1, 8'hC1, 5'b01010, 0, 0);
    applyStimulus(1, 8'hC2, 5'b01010, 0, 0);
    applyStimulus(1, 8'hC3, 5'b00000, 0, 0);
    checkOutput("pre_reset_count", count, 3);
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_count", count, 0);
    checkOutput("midreset_in_ready", in_ready, 1);
    checkOutput("midreset_sticky", sticky_ovf, 0);
    checkOutput("midreset_eq", eq_events, 0);
    expQ.delete();
    mCount = 0; mSticky = 0; mEq = 0;
    in_valid = 1; in_y = 8'hA5;
    {in_less, in_is_eq, in_greater, in_overflow, in_parity} = 5'b00001;
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_reset_push", count, 1);

    // More random traffic after reset, then drain.
    for (int i = 0; i < 100; i++)
      applyStimulus(1'($urandom), 8'($urandom), 5'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
    repeat (6) applyStimulus(0, 8'h00, 5'b0, 1, 0);
    checkOutput("final_empty", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
    $finish;
  end

endmodule
